// File: rtl/uart_tx_if.sv
// Byte-stream handshake into the UART transmitter: valid/ready with 8-bit payload.
interface uart_tx_if;
   logic [7:0] i_data;
   logic       i_valid;
   logic       o_ready;

   modport master (output i_data, output i_valid, input o_ready);
   modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, fed from a small byte FIFO; 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frames).
module uart_tx #(
   parameter int unsigned CLK_FREQ   = 25_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   uart_tx_if.slave                    bus,
   output logic                        o_tx,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   clk_cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            tx_q;
`ifdef UART_TX_PARITY_EN
   logic            parity_q;
`endif

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0] count_q, count_d;
   logic            push_c, pop_c, bit_end_c;
   logic [7:0]      rd_data_c;

   // Ready decodes the registered count only, so a full FIFO refuses a push
   // even on the cycle it pops.
   assign bus.o_ready  = (count_q != CNTW'(FIFO_DEPTH));
   assign push_c       = bus.i_valid && bus.o_ready;
   assign bit_end_c    = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
   assign pop_c        = (count_q != '0) &&
                         ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_c));
   assign count_d      = count_q + CNTW'(push_c) - CNTW'(pop_c);
   assign rd_data_c    = mem_q[rd_ptr_q];

   assign o_tx         = tx_q;
   assign o_busy       = (state_q != S_IDLE) || (count_q != '0);
   assign o_fifo_count = count_q;

   always_ff @(posedge i_clk) begin
      if (push_c) mem_q[wr_ptr_q] <= bus.i_data;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Frame sequencer; every bit boundary falls on bit_end_c.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q      <= 1'b1;
               clk_cnt_q <= '0;
               if (pop_c) begin
                  shift_q  <= rd_data_c;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^rd_data_c;
`endif
                  tx_q     <= 1'b0;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (bit_end_c) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  state_q   <= S_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end_c) begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx_q    <= parity_q;
                     state_q <= S_PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shift_q   <= {1'b0, shift_q[7:1]};
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end_c) begin
                  clk_cnt_q <= '0;
                  tx_q      <= 1'b1;
                  state_q   <= S_STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
`endif
            S_STOP: begin
               if (bit_end_c) begin
                  clk_cnt_q <= '0;
                  // Chain straight into the next start bit when data is waiting.
                  if (pop_c) begin
                     shift_q  <= rd_data_c;
`ifdef UART_TX_PARITY_EN
                     parity_q <= ^rd_data_c;
`endif
                     tx_q     <= 1'b0;
                     state_q  <= S_START;
                  end else begin
                     tx_q     <= 1'b1;
                     state_q  <= S_IDLE;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
